// File: rtl/div32_fast_seq.sv
// Sequential radix-2 restoring divider producing one quotient bit per cycle.
// A dividend with a zero upper half-word needs only half the iterations.
module div32_fast_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW   = $clog2(WIDTH + 1);
  localparam int HALF = WIDTH / 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;

  // The trial value is one bit wider than the divisor: the shifted-in
  // partial remainder can exceed 2^WIDTH-1 when b has its MSB set.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
    trial   = {rem_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, b_q};
    fits    = (trial >= {1'b0, b_q});

    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = b;
          dbz_d = 1'b0;
          if (b == '0) begin
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            dvd_d   = a;
            state_d = FIN;
          end else begin
            rem_d   = '0;
            quo_d   = '0;
            state_d = ITER;
            if (a[WIDTH-1:HALF] == '0) begin
              dvd_d = {a[HALF-1:0], {HALF{1'b0}}};
              cnt_d = HALF_CNT;
            end else begin
              dvd_d = a;
              cnt_d = FULL_CNT;
            end
          end
        end
      end
      ITER: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div32_fast_seq.sv
// Bench for div32_fast_seq: directed vector table, ignored-start and reset
// corner sequences, and randomized operands checked against plain arithmetic.
module tb_div32_fast_seq;

  localparam int W = 32;

  // Handshake: start is sampled only while busy is low; done is a one-cycle
  // pulse with results valid, and results hold until the next accepted start.
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  div32_fast_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int ops_done = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  always @(negedge clk) if (!reset && done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Expected result straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output int lat);
    if (y == 0) begin
      q = '1; r = x; dbz = 1'b1; lat = 1;
    end else begin
      q = x / y; r = x % y; dbz = 1'b0;
      lat = (x < 32'h0001_0000) ? W / 2 + 1 : W + 1;
    end
  endtask

  // Entered at posedge+1 with the divider idle; returns the same way.
  task automatic run_op(input vec_t v, input int poke_at, input string name);
    int n;
    int busy_err;
    logic [W-1:0] eq, er;
    exp_q.push_back(v.q);
    exp_r.push_back(v.r);
    a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 0; busy_err = 0;
    while (!done && n < 2 * W) begin
      if (busy !== 1'b1) busy_err++;
      if (n == poke_at) begin
        start = 1'b1; a = 1; b = 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({name, " done_seen"}, done, 1'b1);
    chk({name, " latency"}, n + 1, v.lat);
    chk({name, " busy_during"}, busy_err, 0);
    chk({name, " busy_at_done"}, busy, 1'b1);
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_by_zero"}, div_by_zero, v.dbz);
    if (v.b != 0)
      chk({name, " invariant"}, {32'd0, quotient} * {32'd0, v.b} + {32'd0, remainder}
          + ((remainder < v.b) ? 64'd0 : 64'd1), {32'd0, v.a});
    ops_done++;
    @(posedge clk); #1;
    chk({name, " done_one_cycle"}, done, 1'b0);
    chk({name, " idle_after"}, busy, 1'b0);
    chk({name, " result_held"}, quotient, eq);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 17};
    tbl[1] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
    tbl[3] = '{32'h1234_5678, 32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    tbl[4] = '{32'd9,         32'd3,          32'd3,          32'd0,          1'b0, 17};
    tbl[5] = '{32'd5,         32'd9,          32'd0,          32'd5,          1'b0, 17};
    tbl[6] = '{32'h8000_0000, 32'h8000_0001,  32'd0,          32'h8000_0000,  1'b0, 33};
    tbl[7] = '{32'd0,         32'd5,          32'd0,          32'd0,          1'b0, 17};
    tbl[8] = '{32'h0001_0000, 32'd1,          32'h0001_0000,  32'd0,          1'b0, 33};
    tbl[9] = '{32'h0000_FFFF, 32'h0000_FFFF,  32'd1,          32'd0,          1'b0, 17};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset div_by_zero", div_by_zero, 1'b0);

    for (int i = 0; i < 10; i++) run_op(tbl[i], -1, $sformatf("vec%0d", i));

    // Start pulsed mid-operation must be ignored.
    run_op('{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 17}, 4, "ignored_start");

    // Reset in the middle of a full-path operation.
    a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort quotient", quotient, 32'd0);
    chk("abort remainder", remainder, 32'd0);
    chk("abort div_by_zero", div_by_zero, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    run_op('{32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0, 33}, -1, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      rv.a = $urandom;
      if ($urandom_range(1, 0) == 1) rv.a = rv.a & 32'h0000_FFFF;
      case ($urandom_range(3, 0))
        0: rv.b = $urandom_range(31, 0);
        1: rv.b = $urandom & 32'h0000_FFFF;
        default: rv.b = $urandom;
      endcase
      model(rv.a, rv.b, rv.q, rv.r, rv.dbz, rv.lat);
      run_op(rv, -1, $sformatf("rand%0d", i));
    end

    @(negedge clk);
    chk("done_pulse_count", done_cnt, ops_done);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
